// File: rtl/div_seq32.sv
// Radix-2 restoring divider, signed/unsigned, quotient and remainder; 33 clocks start-to-done, fixed.
// start is ignored while busy; flush cancels without a done pulse and leaves the last results intact.
module div_seq32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff, a_abs, b_abs, q_fix, r_fix;

    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        ge      = shifted >= {1'b0, dsr_q};
        // When the trial subtraction succeeds the result is below the divisor, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - dsr_q;
        a_abs   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        b_abs   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        q_fix   = qneg_q ? -dvd_q : dvd_q;
        r_fix   = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = a_abs;
                    dsr_d   = b_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = is_signed && dividend[WIDTH-1];
                    dbz_d   = (divisor == '0);
                    ovf_d   = is_signed && (dividend == MIN_NEG) && (divisor == '1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = ge ? diff : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                // Zero divisor leaves rem = |dividend|; re-applying the sign restores the original operand.
                quo_d   = dbz_q ? '1 : (ovf_q ? MIN_NEG : q_fix);
                rmd_d   = ovf_q ? '0 : r_fix;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            quo_d   = quo_q;
            rmd_d   = rmd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
endmodule

// File: doc/div_seq32.md
# div_seq32

Iterative 32-bit integer divider for the MiniSys1A execute stage, the inverse companion of the carry-lookahead adder chain. It computes quotient and remainder for signed (DIV) and unsigned (DIVU) operands by radix-2 restoring division, one quotient bit per clock. It uses a start/busy/done handshake so the pipeline can stall while the operation runs. Results feed the HI (remainder) and LO (quotient) registers.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the block is specified and verified at 32 only.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  32  sampled with start.
- divisor  input  32  sampled with start.
- flush  input  1  synchronous cancel of an in-flight operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on.
- quotient  output  32  registered LO result.
- remainder  output  32  registered HI result.

## Operation
- Reset: busy=0, done=0, quotient=0, remainder=0, state=IDLE, iteration counter=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1: latch |dividend| and |divisor| (absolute value only when is_signed=1), latch sign of quotient (dividend[31]^divisor[31]) and sign of remainder (dividend[31]), latch a div-by-zero flag and a signed-overflow flag; counter=0; busy=1; go to CALC.
- CALC, one step per cycle: shift {partial_rem, dividend_reg} left by 1; trial = partial_rem(33 bits) - {1'b0, divisor_abs}; if trial non-negative, partial_rem=trial and quotient bit=1, else restore and bit=0. Counter increments; after the 32nd step, go to FIX.
- FIX: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. Write quotient/remainder, pulse done, busy=0, go to IDLE.
- Divide by zero (divisor=0, either mode): quotient=0xFFFFFFFF, remainder=dividend as latched (original, unsigned-interpreted). Fixed latency is preserved.
- Signed overflow (0x80000000 / 0xFFFFFFFF, is_signed=1): quotient=0x80000000, remainder=0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy: ignored, no effect on the operation or on the latched operands.
- flush=1: from any state, go to IDLE, busy=0, and no done pulse. quotient/remainder keep their previous values. flush has priority over start in the same cycle.
- quotient/remainder hold until the next FIX write or reset.

## Timing
- start sampled at edge E0 (state IDLE). busy=1 from after E0.
- CALC occupies edges E1..E32. FIX is at edge E33: done=1 and results valid during the cycle after E33, and busy=0 in that same cycle.
- Total latency: 33 clocks from start edge to done, identical for every case including zero divisor and overflow.
- done lasts exactly one cycle. A start asserted during the done cycle is accepted, because the state is already IDLE, giving back-to-back operations every 34 cycles.
- rst_n low at any time forces the reset values immediately, independent of clk. The first start is accepted at the first rising edge after rst_n deasserts.

## Test plan
- Unsigned: 100/7, is_signed=0 -> done exactly 33 edges after start; quotient=14, remainder=2; busy high for 33 cycles.
- Signed: -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/-2 -> quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- Corners: 0x80000000/0xFFFFFFFF signed -> quotient=0x80000000, remainder=0. 5/0 -> quotient=0xFFFFFFFF, remainder=5 with 33-cycle latency. 0/9 -> 0, 0.
- Handshake: second start with different operands mid-operation -> ignored, first result unchanged. start in the done cycle -> accepted, second done 34 cycles after the first.
- flush at CALC step 10 -> busy drops next cycle, no done, outputs retain the prior result. A following start completes normally.
- Assert rst_n low at CALC step 20 -> busy=0, done=0, quotient=0, remainder=0 asynchronously. After release, 1000/10 -> quotient=100, remainder=0.
